logic_reduce_unit: RTL

Parametrised, sequential successor to the two-input bubbled gates. It reduces a stream of 1..MAX_COUNT operands of WIDTH bits with a run-time-selected bitwise operation: AND, OR, XOR, NAND, NOR or XNOR. The result is held in a registered output with a valid/ready handshake. It sits in the CPU datapath beside the ALU and serves multi-operand flag/mask reductions, fed by the register-file read port.

---
 rtl/logic_reduce_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/logic_reduce_unit.sv
// Multi-operand bitwise reducer (AND/OR/XOR and inverted forms): one operand per cycle, result after Count+1 cycles.
// Result is held in DONE until Out_Ready; optional per-index operand inversion when BUBBLES_EN is defined.
module logic_reduce_unit #(
  parameter int                   WIDTH       = 8,
  parameter int                   MAX_COUNT   = 16,
  parameter int                   CNT_W       = $clog2(MAX_COUNT + 1),
  parameter logic [MAX_COUNT-1:0] BubblesMask = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [CNT_W-1:0] Count,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef enum logic [1:0] {FN_AND, FN_OR, FN_XOR} fn_t;

  state_t           state_q, state_d;
  fn_t              fn_q, fn_d, fn_start;
  logic             inv_q, inv_d, inv_start;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_start;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] ident_start;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] combined;

  // N-variants share the base function; inversion is applied once, to the final value only.
  always_comb begin
    fn_start  = FN_OR;
    inv_start = 1'b0;
    case (Op)
      3'b000:  fn_start = FN_AND;
      3'b001:  fn_start = FN_OR;
      3'b010:  fn_start = FN_XOR;
      3'b011:  begin fn_start = FN_AND; inv_start = 1'b1; end
      3'b100:  begin fn_start = FN_OR;  inv_start = 1'b1; end
      3'b101:  begin fn_start = FN_XOR; inv_start = 1'b1; end
      default: fn_start = FN_OR;
    endcase
  end

  assign ident_start = (fn_start == FN_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign cnt_start   = (Count > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : Count;

`ifdef BUBBLES_EN
  localparam int IDX_W = $clog2(MAX_COUNT);
  logic [IDX_W-1:0] bub_idx;
  // idx stays below the clamped count while accumulating, so the low bits address the mask.
  assign bub_idx = idx_q[IDX_W-1:0];
  assign operand = BubblesMask[bub_idx] ? ~Data_In : Data_In;
`else
  assign operand = Data_In;
`endif

  always_comb begin
    case (fn_q)
      FN_AND:  combined = acc_q & operand;
      FN_XOR:  combined = acc_q ^ operand;
      default: combined = acc_q | operand;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    res_d     = res_q;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          fn_d  = fn_start;
          inv_d = inv_start;
          cnt_d = cnt_start;
          acc_d = ident_start;
          idx_d = '0;
          if (cnt_start == '0) begin
            res_d   = ident_start ^ {WIDTH{inv_start}};
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
        if (In_Valid) begin
          acc_d = combined;
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == cnt_q - CNT_W'(1)) begin
            res_d   = combined ^ {WIDTH{inv_q}};
            state_d = DONE;
          end
        end
      end
      DONE: begin
        Out_Valid = 1'b1;
        Busy      = 1'b1;
        if (Out_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fn_q  <= FN_AND;
      inv_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      fn_q  <= fn_d;
      inv_q <= inv_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign Result = res_q;

endmodule
